mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 20, word-address width.
REQ-002 SHALL have parameter TMO, default 255, timeout in cycles, range 1..255, used only under ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports c_req and i_req, input, 1 each, access request: CPU (port 0) and I/O channel (port 1).
REQ-006 SHALL have ports c_we and i_we, input, 1 each, 1=write, 0=read.
REQ-007 SHALL have ports c_lock and i_lock, input, 1 each, atomic read-modify-write lock.
REQ-008 SHALL have ports c_addr and i_addr, input, AW each; c_wdata and i_wdata, input, 64 each; c_wtag and i_wtag, input, 8 each.
REQ-009 SHALL have ports c_ack and i_ack, output, 1 each, one-cycle completion pulse.
REQ-010 SHALL have ports rdata, output, 64; rtag, output, 8; err, output, 1. All three are shared and valid only while an ack is high.
REQ-011 SHALL have ports m_astb, m_rd and m_wr, output, 1 each, memory strobe/read/write.
REQ-012 SHALL have ports m_addr, output, AW; m_wdata, output, 64; m_wtag, output, 8.
REQ-013 SHALL have ports m_rdata, input, 64; m_rtag, input, 8; m_ready, input, 1, memory done.
REQ-014 SHALL have port m_atomic, output, 1, bus locked for RMW.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, WAIT, DONE.
REQ-016 IDLE: when at least one request is present, SHALL select the winner and latch its addr, wdata, wtag and we into m_* registers, then go to ADDR.
REQ-017 Winner selection SHALL be round-robin: the port not served last wins a tie; after reset CPU has priority.
REQ-018 ADDR: SHALL assert m_astb for exactly 1 cycle, plus m_rd=!we or m_wr=we; then go to WAIT.
REQ-019 WAIT: SHALL hold m_rd/m_wr and stay in WAIT until m_ready=1. m_ready is ignored in all other states.
REQ-020 On m_ready, SHALL capture m_rdata and m_rtag (reads only; writes give rdata=0, rtag=0), then go to DONE.
REQ-021 DONE: SHALL pulse the winner's ack for 1 cycle, then go to IDLE. Minimum access is 4 cycles: req sampled to ack.
REQ-022 A requester SHALL hold req and its inputs stable until its ack; deasserting req mid-access does not abort the access.
REQ-023 Lock: a granted access with lock=1 SHALL set owner-lock. While owner-lock is set, only the owner is granted, even if the other port requests. m_atomic=1 from ADDR of the locking access to DONE of the owner's first lock=0 access.
REQ-024 If the owner drops req while locked and idle, SHALL clear the lock when req=0 is seen in IDLE.
REQ-025 Simultaneous req, with no lock held, SHALL be served in round-robin order; a port never waits more than one access.
REQ-026 Outputs SHALL be registered; no combinational path from any *_req to m_*.

Reset
REQ-027 Reset SHALL force IDLE, with all acks, m_astb, m_rd, m_wr, m_atomic and err at 0.
REQ-028 Reset SHALL clear m_addr, m_wdata, m_wtag, rdata and rtag to 0, clear the lock, and set last-served to I/O.
REQ-029 Reset asserted mid-access SHALL abort it with no ack; the memory side sees strobes drop asynchronously.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined: an 8-bit counter SHALL run in WAIT. When it reaches TMO without m_ready, SHALL go to DONE with err=1, rdata=0 and the lock cleared; it counts from 0 on WAIT entry.
REQ-031 Without ARB_TIMEOUT_EN: no counter, err tied 0, WAIT unbounded.

Verification
REQ-032 c_req read of addr 0x00010 (m_rdata=0x0123456789ABCDEF, m_rtag=0x35), m_ready 2 cycles after astb -> c_ack in cycle 5, rdata/rtag match, i_ack=0.
REQ-033 c_req and i_req both held, 4 writes -> grant order CPU, I/O, CPU, I/O; each m_astb is 1 cycle.
REQ-034 CPU read with c_lock=1, then write with lock=0, while i_req is held -> both CPU accesses served first; m_atomic high across them; I/O served third.
REQ-035 Reset pulsed during WAIT of an I/O read -> no i_ack; all outputs 0; the next request gets CPU priority.
REQ-036 With ARB_TIMEOUT_EN and TMO=10, m_ready never asserted -> ack with err=1 and rdata=0 after 10 WAIT cycles; without the macro the bench sees no ack after 1000 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (CPU / I/O) round-robin memory arbiter with RMW lock.
//            Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int AW  = 20,
   parameter int TMO = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          i_req,
   input  logic          c_we,
   input  logic          i_we,
   input  logic          c_lock,
   input  logic          i_lock,
   input  logic [AW-1:0] c_addr,
   input  logic [AW-1:0] i_addr,
   input  logic [63:0]   c_wdata,
   input  logic [63:0]   i_wdata,
   input  logic [7:0]    c_wtag,
   input  logic [7:0]    i_wtag,
   output logic          c_ack,
   output logic          i_ack,
   output logic [63:0]   rdata,
   output logic [7:0]    rtag,
   output logic          err,
   output logic          m_astb,
   output logic          m_rd,
   output logic          m_wr,
   output logic [AW-1:0] m_addr,
   output logic [63:0]   m_wdata,
   output logic [7:0]    m_wtag,
   input  logic [63:0]   m_rdata,
   input  logic [7:0]    m_rtag,
   input  logic          m_ready,
   output logic          m_atomic
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   generate
      if (TMO < 1 || TMO > 255) begin : g_tmo_range_err
         $error("mem_arbiter: TMO must be within 1..255");
      end
   endgenerate

   state_t r_state;
   logic   r_last;        // port served last: 0 = CPU, 1 = I/O
   logic   r_owner;
   logic   r_lock_held;
   logic   r_cur_port;
   logic   r_cur_we;
   logic   r_cur_lock;

   logic   w_grant;
   logic   w_win;
   logic   w_drop_lock;
   logic   w_owner_req;
   logic   w_sel_we;
   logic   w_sel_lock;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] C_TMO = 8'(TMO);
   logic [7:0] r_tmo_cnt;
   logic       r_err;
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign w_owner_req = r_owner ? i_req : c_req;
   assign w_sel_we    = w_win ? i_we   : c_we;
   assign w_sel_lock  = w_win ? i_lock : c_lock;

   always_comb begin
      w_grant     = 1'b0;
      w_win       = 1'b0;
      w_drop_lock = 1'b0;
      if (r_lock_held) begin
         if (w_owner_req) begin
            w_grant = 1'b1;
            w_win   = r_owner;
         end else begin
            w_drop_lock = 1'b1;
         end
      end else if (c_req && i_req) begin
         w_grant = 1'b1;
         w_win   = ~r_last;
      end else if (c_req || i_req) begin
         w_grant = 1'b1;
         w_win   = i_req;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_last      <= 1'b1;
         r_owner     <= 1'b0;
         r_lock_held <= 1'b0;
         r_cur_port  <= 1'b0;
         r_cur_we    <= 1'b0;
         r_cur_lock  <= 1'b0;
         c_ack       <= 1'b0;
         i_ack       <= 1'b0;
         rdata       <= '0;
         rtag        <= '0;
         m_astb      <= 1'b0;
         m_rd        <= 1'b0;
         m_wr        <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         m_wtag      <= '0;
         m_atomic    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_tmo_cnt   <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         c_ack  <= 1'b0;
         i_ack  <= 1'b0;
         m_astb <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_drop_lock) begin
                  r_lock_held <= 1'b0;
                  m_atomic    <= 1'b0;
               end else if (w_grant) begin
                  r_cur_port <= w_win;
                  r_cur_we   <= w_sel_we;
                  r_cur_lock <= w_sel_lock;
                  r_last     <= w_win;
                  m_addr     <= w_win ? i_addr  : c_addr;
                  m_wdata    <= w_win ? i_wdata : c_wdata;
                  m_wtag     <= w_win ? i_wtag  : c_wtag;
                  m_astb     <= 1'b1;
                  m_rd       <= ~w_sel_we;
                  m_wr       <= w_sel_we;
                  if (w_sel_lock) begin
                     r_lock_held <= 1'b1;
                     r_owner     <= w_win;
                     m_atomic    <= 1'b1;
                  end
                  r_state <= ADDR;
               end
            end
            ADDR: begin
`ifdef ARB_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
               r_state <= WAIT;
            end
            WAIT: begin
               if (m_ready) begin
                  m_rd    <= 1'b0;
                  m_wr    <= 1'b0;
                  rdata   <= r_cur_we ? 64'd0 : m_rdata;
                  rtag    <= r_cur_we ? 8'd0  : m_rtag;
                  c_ack   <= ~r_cur_port;
                  i_ack   <= r_cur_port;
                  r_state <= DONE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_tmo_cnt + 8'd1 == C_TMO) begin
                  // Abandon the access: report error and release any lock.
                  m_rd        <= 1'b0;
                  m_wr        <= 1'b0;
                  rdata       <= '0;
                  rtag        <= '0;
                  r_err       <= 1'b1;
                  r_lock_held <= 1'b0;
                  m_atomic    <= 1'b0;
                  c_ack       <= ~r_cur_port;
                  i_ack       <= r_cur_port;
                  r_state     <= DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
`endif
            end
            DONE: begin
`ifdef ARB_TIMEOUT_EN
               r_err <= 1'b0;
`endif
               // The first unlocked access by the owner ends the atomic window.
               if (!r_cur_lock) begin
                  r_lock_held <= 1'b0;
                  m_atomic    <= 1'b0;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (TMO = 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          c_req = 1'b0, i_req = 1'b0;
   logic          c_we = 1'b0, i_we = 1'b0;
   logic          c_lock = 1'b0, i_lock = 1'b0;
   logic [AW-1:0] c_addr = '0, i_addr = '0;
   logic [63:0]   c_wdata = '0, i_wdata = '0;
   logic [7:0]    c_wtag = '0, i_wtag = '0;
   logic          c_ack, i_ack;
   logic [63:0]   rdata;
   logic [7:0]    rtag;
   logic          err;
   logic          m_astb, m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [63:0]   m_wdata;
   logic [7:0]    m_wtag;
   logic [63:0]   m_rdata = '0;
   logic [7:0]    m_rtag = '0;
   logic          m_ready;
   logic          m_atomic;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .TMO(10)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .i_req(i_req), .c_we(c_we), .i_we(i_we),
      .c_lock(c_lock), .i_lock(i_lock), .c_addr(c_addr), .i_addr(i_addr),
      .c_wdata(c_wdata), .i_wdata(i_wdata), .c_wtag(c_wtag), .i_wtag(i_wtag),
      .c_ack(c_ack), .i_ack(i_ack), .rdata(rdata), .rtag(rtag), .err(err),
      .m_astb(m_astb), .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wtag(m_wtag), .m_rdata(m_rdata), .m_rtag(m_rtag),
      .m_ready(m_ready), .m_atomic(m_atomic)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: m_ready pulses mem_delay cycles after the strobe (0 = never).
   int mem_delay = 0;
   int rd_cnt = 0;
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_ready = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) m_ready = 1'b1;
         end
         if (m_astb && mem_delay > 0) rd_cnt = mem_delay;
      end
   end

   // Bus monitor: strobe count/width, last granted command, ack counts.
   int            astb_cnt = 0, astb_multi = 0, ack_i_cnt = 0, atomic_low = 0;
   logic          prev_astb = 1'b0;
   logic          watch = 1'b0;
   logic [AW-1:0] g_addr = '0;
   logic [1:0]    g_rdwr = '0;
   logic [63:0]   g_wdata = '0;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (m_astb) begin
            astb_cnt++;
            if (prev_astb) astb_multi++;
            g_addr  = m_addr;
            g_rdwr  = {m_rd, m_wr};
            g_wdata = m_wdata;
         end
         prev_astb = m_astb;
         if (i_ack) ack_i_cnt++;
         if (watch && !m_atomic) atomic_low++;
      end
   end

   task automatic wait_ack(input int budget, output int n, output logic port);
      n    = -1;
      port = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         if (c_ack || i_ack) begin
            n    = k;
            port = i_ack;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int         n;
      int         base, base2;
      int         nc, ni;
      logic       port;
      logic [3:0] seq;

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("rst_ctl", {c_ack, i_ack, m_astb, m_rd, m_wr, m_atomic, err}, 7'd0);
      check("rst_addr", m_addr, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rtag", rtag, 0);
      check("rst_wdata_wtag", {m_wdata[55:0], m_wtag}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // CPU read, m_ready two cycles after the strobe
      mem_delay = 2;
      m_rdata = 64'h0123456789ABCDEF;
      m_rtag  = 8'h35;
      c_addr = 20'h00010; c_we = 1'b0; c_lock = 1'b0; c_req = 1'b1;
      base = ack_i_cnt;
      wait_ack(20, n, port);
      check("t1_ack_cycle", n + 1, 5);
      check("t1_port", port, 0);
      check("t1_rdata", rdata, 64'h0123456789ABCDEF);
      check("t1_rtag", rtag, 8'h35);
      check("t1_err", err, 0);
      check("t1_addr", g_addr, 20'h00010);
      check("t1_rdwr", g_rdwr, 2'b10);
      c_req = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("t1_no_i_ack", ack_i_cnt - base, 0);

      // Both ports writing: strict alternation starting with CPU after reset
      do_reset();
      mem_delay = 1;
      c_we = 1'b1; c_addr = 20'h00100; c_wdata = 64'h1111; c_wtag = 8'h11;
      i_we = 1'b1; i_addr = 20'h00200; i_wdata = 64'h2222; i_wtag = 8'h22;
      c_req = 1'b1; i_req = 1'b1;
      base = astb_cnt; base2 = astb_multi;
      seq = '0; nc = 0; ni = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(30, n, port);
         seq = {seq[2:0], port};
         if (k == 0) check("t2_wr_rdata", rdata, 0);
         if (port) begin
            ni++;
            if (ni == 2) i_req = 1'b0;
         end else begin
            nc++;
            if (nc == 2) c_req = 1'b0;
         end
      end
      c_req = 1'b0; i_req = 1'b0;
      check("t2_order", seq, 4'b0101);
      check("t2_astb_cnt", astb_cnt - base, 4);
      check("t2_astb_1cyc", astb_multi - base2, 0);
      check("t2_last_rdwr", g_rdwr, 2'b01);
      check("t2_last_wdata", g_wdata, 64'h2222);

      // Locked CPU read then unlocked write, I/O held waiting
      m_rdata = 64'hFEEDFACECAFEBABE; m_rtag = 8'h5A;
      c_addr = 20'h00300; c_we = 1'b0; c_lock = 1'b1; c_req = 1'b1;
      i_addr = 20'h00400; i_we = 1'b0; i_lock = 1'b0; i_req = 1'b1;
      wait_ack(30, n, port);
      check("t3_first_port", port, 0);
      check("t3_first_atomic", m_atomic, 1);
      check("t3_first_rdata", rdata, 64'hFEEDFACECAFEBABE);
      c_lock = 1'b0; c_we = 1'b1; c_wdata = 64'h3333;
      base = atomic_low;
      watch = 1'b1;
      wait_ack(30, n, port);
      watch = 1'b0;
      check("t3_second_port", port, 0);
      check("t3_second_atomic", m_atomic, 1);
      check("t3_second_rdwr", g_rdwr, 2'b01);
      check("t3_atomic_held", atomic_low - base, 0);
      c_req = 1'b0;
      @(posedge clk); #1;
      check("t3_atomic_release", m_atomic, 0);
      wait_ack(30, n, port);
      check("t3_third_port", port, 1);
      check("t3_third_addr", g_addr, 20'h00400);
      check("t3_third_atomic", m_atomic, 0);
      i_req = 1'b0;
      @(posedge clk); #1;

      // Reset during WAIT of an I/O read
      mem_delay = 0;
      i_addr = 20'h00500; i_we = 1'b0; i_req = 1'b1;
      base = ack_i_cnt;
      repeat (3) @(posedge clk); #1;
      check("t4_in_wait", {m_astb, m_rd, m_wr}, 3'b010);
      #2 reset = 1'b1;
      i_req = 1'b0;
      #1;
      check("t4_rst_ctl", {c_ack, i_ack, m_astb, m_rd, m_wr, m_atomic, err}, 7'd0);
      check("t4_rst_addr", m_addr, 0);
      check("t4_rst_rdata", rdata, 0);
      check("t4_rst_wtag", m_wtag, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("t4_no_i_ack", ack_i_cnt - base, 0);
      mem_delay = 1;
      c_addr = 20'h00600; c_we = 1'b0; c_req = 1'b1;
      i_addr = 20'h00700; i_req = 1'b1;
      wait_ack(30, n, port);
      check("t4_cpu_first", port, 0);
      c_req = 1'b0;
      wait_ack(30, n, port);
      check("t4_io_second", port, 1);
      i_req = 1'b0;
      @(posedge clk); #1;

      // Memory never answers
      mem_delay = 0;
      c_addr = 20'h00800; c_we = 1'b0; c_req = 1'b1;
`ifdef ARB_TIMEOUT_EN
      wait_ack(40, n, port);
      check("t5_tmo_latency", n, 12);
      check("t5_tmo_port", port, 0);
      check("t5_tmo_err", err, 1);
      check("t5_tmo_rdata", rdata, 0);
      c_req = 1'b0;
      @(posedge clk); #1;
      check("t5_err_clear", {err, c_ack}, 2'b00);
`else
      wait_ack(1000, n, port);
      check("t5_no_ack", n < 0, 1);
      check("t5_still_wait", {m_astb, m_rd}, 2'b01);
      c_req = 1'b0;
      do_reset();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
